// File: rtl/conv_layer_seq.sv
// conv_layer_seq: layer sequencer for the 3xN convolution AGU.
// Accepts one layer command and programs the AGU configuration from it. It
// runs the AGU once per input-channel pass, delays the window-end strobe to
// line up with the MAC result, and raises accum_en on every pass after the
// first.
// Ports: clk, reset (async, active-high); cmd_* command handshake and fields;
//   abort; agu_*_cfg registered command copies; agu_clr/agu_start AGU control;
//   agu_win_end/agu_done AGU status; en_result_addr result write strobe;
//   accum_en, busy, layer_done status.
// Optional: define LAYER_SEQ_PERF_EN to add perf_cycles/perf_stall counters.
module conv_layer_seq #(
    parameter int KERN_COL_WIDTH  = 3,
    parameter int COL_WIDTH       = 8,
    parameter int KERN_CNT_WIDTH  = 3,
    parameter int IMG_ADDR_WIDTH  = 8,
    parameter int RSLT_ADDR_WIDTH = 8,
    parameter int PASS_WIDTH      = 4,
    parameter int PIPE_LAT        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [KERN_COL_WIDTH-1:0]  cmd_kern_cols,
    input  logic [COL_WIDTH-1:0]       cmd_cols,
    input  logic [KERN_CNT_WIDTH-1:0]  cmd_kerns,
    input  logic [IMG_ADDR_WIDTH-1:0]  cmd_stride,
    input  logic                       cmd_kern_addr_mode,
    input  logic [RSLT_ADDR_WIDTH-1:0] cmd_result_cols,
    input  logic [PASS_WIDTH-1:0]      cmd_passes,
    input  logic                       abort,
    output logic [KERN_COL_WIDTH-1:0]  agu_kern_cols_cfg,
    output logic [COL_WIDTH-1:0]       agu_cols_cfg,
    output logic [KERN_CNT_WIDTH-1:0]  agu_kerns_cfg,
    output logic [IMG_ADDR_WIDTH-1:0]  agu_stride_cfg,
    output logic                       agu_kern_addr_mode_cfg,
    output logic [RSLT_ADDR_WIDTH-1:0] agu_result_cols_cfg,
    output logic [PASS_WIDTH-1:0]      agu_passes_cfg,
    output logic                       agu_clr,
    output logic                       agu_start,
    input  logic                       agu_win_end,
    input  logic                       agu_done,
    output logic                       en_result_addr,
    output logic                       accum_en,
    output logic                       busy,
    output logic                       layer_done
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [31:0]                perf_cycles,
    output logic [31:0]                perf_stall
`endif
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;
    localparam int FW = $clog2(PIPE_LAT + 1);

    state_t                     state_q, state_d;
    logic [PASS_WIDTH-1:0]      pass_q, pass_d;
    logic [FW-1:0]              cnt_q, cnt_d;
    logic [PIPE_LAT-1:0]        dl_q, dl_d;
    logic                       first_q, accum_q;
    logic [KERN_COL_WIDTH-1:0]  kern_cols_q;
    logic [COL_WIDTH-1:0]       cols_q;
    logic [KERN_CNT_WIDTH-1:0]  kerns_q;
    logic [IMG_ADDR_WIDTH-1:0]  stride_q;
    logic                       mode_q;
    logic [RSLT_ADDR_WIDTH-1:0] rcols_q;
    logic [PASS_WIDTH-1:0]      passes_q;
    logic                       accept, abort_act;

    assign accept    = cmd_valid && state_q == IDLE;
    assign abort_act = abort && state_q != IDLE;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        cnt_d   = '0;
        case (state_q)
            IDLE:  if (cmd_valid) begin
                state_d = LOAD;
                pass_d  = '0;
            end
            LOAD:  state_d = RUN;
            // first_q masks a done seen on the RUN entry cycle
            RUN:   if (agu_done && !first_q) state_d = FLUSH;
            FLUSH: if (cnt_q == FW'(PIPE_LAT - 1)) begin
                if (pass_q == passes_q) state_d = DONE;
                else begin
                    state_d = LOAD;
                    pass_d  = pass_q + 1'b1;
                end
            end else cnt_d = cnt_q + 1'b1;
            DONE: begin
                state_d = IDLE;
                pass_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        if (abort_act) begin
            state_d = IDLE;
            pass_d  = '0;
        end
    end

    // Window-end delay line; emptied on LOAD and abort so stale strobes
    // from an abandoned pass never reach the result RAM.
    always_comb begin
        dl_d = '0;
        if (!(abort_act || state_q == LOAD)) begin
            dl_d[0] = agu_win_end;
            for (int i = 1; i < PIPE_LAT; i++) dl_d[i] = dl_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            cnt_q       <= '0;
            dl_q        <= '0;
            first_q     <= 1'b0;
            accum_q     <= 1'b0;
            kern_cols_q <= '0;
            cols_q      <= '0;
            kerns_q     <= '0;
            stride_q    <= '0;
            mode_q      <= 1'b0;
            rcols_q     <= '0;
            passes_q    <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            dl_q    <= dl_d;
            first_q <= state_q == LOAD;
            accum_q <= pass_d != '0;
            if (accept) begin
                kern_cols_q <= cmd_kern_cols;
                cols_q      <= cmd_cols;
                kerns_q     <= cmd_kerns;
                stride_q    <= cmd_stride;
                mode_q      <= cmd_kern_addr_mode;
                rcols_q     <= cmd_result_cols;
                passes_q    <= cmd_passes;
            end
        end
    end

    assign cmd_ready              = state_q == IDLE;
    assign busy                   = state_q != IDLE;
    assign agu_clr                = state_q == LOAD || abort_act;
    assign agu_start              = state_q == RUN && !abort;
    assign layer_done             = state_q == DONE && !abort;
    assign en_result_addr         = dl_q[PIPE_LAT-1];
    assign accum_en               = accum_q;
    assign agu_kern_cols_cfg      = kern_cols_q;
    assign agu_cols_cfg           = cols_q;
    assign agu_kerns_cfg          = kerns_q;
    assign agu_stride_cfg         = stride_q;
    assign agu_kern_addr_mode_cfg = mode_q;
    assign agu_result_cols_cfg    = rcols_q;
    assign agu_passes_cfg         = passes_q;

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] cyc_q, stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (accept) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (state_q != IDLE && ~&cyc_q) cyc_q <= cyc_q + 32'd1;
            if ((state_q == LOAD || state_q == FLUSH) && ~&stall_q) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_cycles = cyc_q;
    assign perf_stall  = stall_q;
`endif
endmodule

// File: tb/tb_conv_layer_seq.sv
// tb_conv_layer_seq: self-checking bench for conv_layer_seq (PIPE_LAT=4).
module tb_conv_layer_seq;
    logic       clk = 1'b0;
    logic       reset, cmd_valid, cmd_ready, cmd_kern_addr_mode, abort;
    logic [2:0] cmd_kern_cols, cmd_kerns, agu_kern_cols_cfg, agu_kerns_cfg;
    logic [7:0] cmd_cols, cmd_stride, cmd_result_cols;
    logic [7:0] agu_cols_cfg, agu_stride_cfg, agu_result_cols_cfg;
    logic [3:0] cmd_passes, agu_passes_cfg;
    logic       agu_kern_addr_mode_cfg, agu_clr, agu_start, agu_win_end, agu_done;
    logic       en_result_addr, accum_en, busy, layer_done;
`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    conv_layer_seq dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kern_cols(cmd_kern_cols), .cmd_cols(cmd_cols), .cmd_kerns(cmd_kerns),
        .cmd_stride(cmd_stride), .cmd_kern_addr_mode(cmd_kern_addr_mode),
        .cmd_result_cols(cmd_result_cols), .cmd_passes(cmd_passes), .abort(abort),
        .agu_kern_cols_cfg(agu_kern_cols_cfg), .agu_cols_cfg(agu_cols_cfg),
        .agu_kerns_cfg(agu_kerns_cfg), .agu_stride_cfg(agu_stride_cfg),
        .agu_kern_addr_mode_cfg(agu_kern_addr_mode_cfg),
        .agu_result_cols_cfg(agu_result_cols_cfg), .agu_passes_cfg(agu_passes_cfg),
        .agu_clr(agu_clr), .agu_start(agu_start), .agu_win_end(agu_win_end),
        .agu_done(agu_done), .en_result_addr(en_result_addr), .accum_en(accum_en),
        .busy(busy), .layer_done(layer_done)
`ifdef LAYER_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int d;
        int done_c;
        int clr;
        int start;
    } vec_t;

    int n_cmp = 0, n_fail = 0, gc = 0;
    bit we_hist[0:16383];
    bit fl_hist[0:16383];
    bit flush_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, gc, act, exp);
        end
    endtask

    // Result strobe model: a window end seen at cycle t shows up at t+4 unless
    // a LOAD or abort falls in cycles t..t+3 and flushes it.
    task automatic sample();
        bit e;
        @(negedge clk);
        e = 0;
        if (gc >= 4) begin
            e = we_hist[gc-4];
            for (int i = 1; i <= 4; i++) if (fl_hist[gc-i]) e = 0;
        end
        chk("en_result_addr", en_result_addr, e);
        we_hist[gc] = agu_win_end;
        fl_hist[gc] = flush_exp;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        gc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 0; agu_done = 0; abort = 0; flush_exp = 0;
            agu_win_end = $urandom_range(0, 3) == 0;
            sample();
            chk("idle_ready", cmd_ready, 1);
            chk("idle_busy", busy, 0);
            adv();
        end
    endtask

    // Open-loop layer: pass k loads at L[k], runs L[k]+1..L[k]+1+d[k],
    // flushes 4 cycles, so L[k+1] = L[k]+d[k]+6 and DONE follows the last pass.
    task automatic run_layer(input int p, input int dv[4], input bit keep,
                             output int done_c, output int n_clr, output int n_start);
        int L[5];
        int last;
        cmd_kern_cols = 3'($urandom); cmd_cols = 8'($urandom); cmd_kerns = 3'($urandom);
        cmd_stride = 8'($urandom); cmd_kern_addr_mode = 1'($urandom);
        cmd_result_cols = 8'($urandom); cmd_passes = 4'(p);
        L[0] = 1;
        for (int k = 1; k <= p; k++) L[k] = L[k-1] + dv[k-1] + 6;
        last = L[p] + dv[p] + 6;
        done_c = -1; n_clr = 0; n_start = 0;
        for (int c = 0; c <= last; c++) begin
            int pk = 0;
            bit isl = 0, run = 0, dn = 0;
            for (int j = 0; j <= p; j++) begin
                if (c >= L[j]) pk = j;
                if (c == L[j]) isl = 1;
                if (c >= L[j] + 1 && c <= L[j] + 1 + dv[j]) run = 1;
                if (c >= L[j] + 1 + dv[j] && c <= ((j == p) ? last : L[j+1])) dn = 1;
            end
            cmd_valid = (c == 0) || keep; agu_done = dn; abort = 0; flush_exp = isl;
            agu_win_end = $urandom_range(0, 3) == 0;
            sample();
            chk("cmd_ready", cmd_ready, c == 0);
            chk("busy", busy, c != 0);
            chk("agu_clr", agu_clr, isl);
            chk("agu_start", agu_start, run);
            chk("layer_done", layer_done, c == last);
            if (c >= 1) chk("accum_en", accum_en, pk != 0);
            if (c == 1 || c == last) begin
                chk("cfg_a", {agu_kern_cols_cfg, agu_cols_cfg, agu_kerns_cfg, agu_stride_cfg},
                    {cmd_kern_cols, cmd_cols, cmd_kerns, cmd_stride});
                chk("cfg_b", {agu_kern_addr_mode_cfg, agu_result_cols_cfg, agu_passes_cfg},
                    {cmd_kern_addr_mode, cmd_result_cols, cmd_passes});
            end
            if (agu_clr) n_clr++;
            if (agu_start) n_start++;
            if (layer_done && done_c < 0) done_c = c;
            adv();
        end
        cmd_valid = keep; agu_done = 0;
    endtask

    initial begin
        vec_t tbl[5];
        int dv[4];
        int dc, nc, ns;
        tbl[0] = '{0, 20, 27, 1, 21};
        tbl[1] = '{2, 3, 28, 3, 12};
        tbl[2] = '{1, 1, 15, 2, 4};
        tbl[3] = '{3, 5, 45, 4, 24};
        tbl[4] = '{0, 1, 8, 1, 2};

        reset = 1; cmd_valid = 0; abort = 0; agu_done = 0; agu_win_end = 0;
        cmd_kern_cols = 0; cmd_cols = 0; cmd_kerns = 0; cmd_stride = 0;
        cmd_kern_addr_mode = 0; cmd_result_cols = 0; cmd_passes = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_outs", {busy, agu_clr, agu_start, en_result_addr, accum_en, layer_done}, 0);
        chk("rst_cfg", {agu_kern_cols_cfg, agu_cols_cfg, agu_kerns_cfg, agu_stride_cfg,
                        agu_kern_addr_mode_cfg, agu_passes_cfg}, 0);
        chk("rst_rcols", agu_result_cols_cfg, 0);
        @(posedge clk); #1;
        reset = 0;
        idle(2);

        foreach (tbl[i]) begin
            for (int k = 0; k < 4; k++) dv[k] = tbl[i].d;
            run_layer(tbl[i].p, dv, 0, dc, nc, ns);
            chk("done_cycle", dc, tbl[i].done_c);
            chk("clr_pulses", nc, tbl[i].clr);
            chk("start_cycles", ns, tbl[i].start);
            idle(3);
        end

        // cmd_valid held high: next command taken only on the cycle after layer_done
        for (int k = 0; k < 4; k++) dv[k] = 2;
        run_layer(1, dv, 1, dc, nc, ns);
        run_layer(0, dv, 0, dc, nc, ns);
        chk("b2b_done", dc, 9);
        idle(2);

        // abort in RUN with a window end in flight
        for (int c = 0; c < 13; c++) begin
            cmd_valid = c == 0; cmd_passes = 0; agu_done = 0;
            agu_win_end = c == 3; abort = c == 5; flush_exp = c == 1 || c == 5;
            sample();
            if (c == 1) chk("ab_load_clr", agu_clr, 1);
            if (c == 3) chk("ab_run_start", agu_start, 1);
            if (c == 5) chk("ab_clr", {agu_clr, agu_start, layer_done}, 3'b100);
            if (c >= 6) chk("ab_idle", {cmd_ready, busy, agu_clr, layer_done}, 4'b1000);
            adv();
        end

        // abort while IDLE is ignored; abort in LOAD returns to IDLE
        for (int c = 0; c < 3; c++) begin
            cmd_valid = c == 0; abort = c < 2; agu_win_end = 0; flush_exp = c == 1;
            sample();
            if (c == 0) chk("idle_abort_clr", {agu_clr, cmd_ready}, 2'b01);
            if (c == 1) chk("load_abort", {agu_clr, busy}, 2'b11);
            if (c == 2) chk("load_abort_idle", {cmd_ready, busy, agu_clr}, 3'b100);
            adv();
        end

        // asynchronous reset in the middle of RUN
        for (int c = 0; c < 4; c++) begin
            cmd_valid = c == 0; cmd_passes = 0; abort = 0; agu_done = 0;
            agu_win_end = 0; flush_exp = c == 1;
            sample();
            if (c == 3) chk("pre_rst_start", agu_start, 1);
            if (c < 3) adv();
        end
        cmd_valid = 0;
        reset = 1;
        #1;
        chk("mid_rst", {cmd_ready, agu_start, busy, agu_clr, en_result_addr}, 5'b10000);
        adv();
        reset = 0;
        for (int i = 0; i <= gc; i++) we_hist[i] = 0;
        idle(2);

        repeat (25) begin
            int p;
            bit keep;
            p = $urandom_range(0, 3);
            keep = $urandom_range(0, 1) == 1;
            for (int k = 0; k < 4; k++) dv[k] = $urandom_range(1, 10);
            run_layer(p, dv, keep, dc, nc, ns);
            chk("rnd_clr", nc, p + 1);
            if (!keep) idle($urandom_range(1, 3));
        end
        cmd_valid = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
